// File: rtl/vga_sync_ctrl.sv
// 640x480@60 Hz VGA timing generator: pixel-enable divider, position counters,
// horizontal phase FSM and sync/blank decodes for the pixel memory.
module vga_sync_ctrl #(
    parameter int unsigned DIV   = 2,
    parameter int unsigned H_VIS = 640,
    parameter int unsigned H_FP  = 16,
    parameter int unsigned H_SYN = 96,
    parameter int unsigned H_BP  = 48,
    parameter int unsigned V_VIS = 480,
    parameter int unsigned V_FP  = 10,
    parameter int unsigned V_SYN = 2,
    parameter int unsigned V_BP  = 33
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       en,
    output logic       pix_tick,
    output logic [9:0] Posx,
    output logic [9:0] Posy,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYN + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYN + V_BP;
    localparam int unsigned DW    = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0]    X_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]    Y_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0]    X_FRONT  = 10'(H_VIS);
    localparam logic [9:0]    X_SYNC   = 10'(H_VIS + H_FP);
    localparam logic [9:0]    X_BACK   = 10'(H_VIS + H_FP + H_SYN);
    localparam logic [9:0]    Y_VIS    = 10'(V_VIS);
    localparam logic [9:0]    Y_SYN0   = 10'(V_VIS + V_FP);
    localparam logic [9:0]    Y_SYN1   = 10'(V_VIS + V_FP + V_SYN);

    typedef enum logic [1:0] {
        H_ACTIVE,
        H_FRONT,
        H_SYNC,
        H_BACK
    } h_state_t;

    h_state_t      h_state;
    h_state_t      h_nxt;
    logic [DW-1:0] div_cnt;
    logic          wrap_q;
    logic          line_end;
    logic          frame_end;
    logic [9:0]    posx_nxt;
    logic [9:0]    posy_nxt;

    // Next position and phase, applied only on edges that consume a pixel tick.
    always_comb begin
        line_end  = (Posx == X_LAST);
        frame_end = line_end && (Posy == Y_LAST);
        posx_nxt  = line_end ? 10'd0 : Posx + 10'd1;
        posy_nxt  = Posy;
        if (frame_end) begin
            posy_nxt = 10'd0;
        end else if (line_end) begin
            posy_nxt = Posy + 10'd1;
        end
        h_nxt = h_state;
        if (posx_nxt == 10'd0) begin
            h_nxt = H_ACTIVE;
        end else if (posx_nxt == X_FRONT) begin
            h_nxt = H_FRONT;
        end else if (posx_nxt == X_SYNC) begin
            h_nxt = H_SYNC;
        end else if (posx_nxt == X_BACK) begin
            h_nxt = H_BACK;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            div_cnt     <= '0;
            pix_tick    <= 1'b0;
            Posx        <= 10'd0;
            Posy        <= 10'd0;
            h_state     <= H_ACTIVE;
            wrap_q      <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            pix_tick <= (div_cnt == DIV_LAST);
            // wrap_q survives an en=0 gap so a pending frame_start is not lost.
            wrap_q      <= pix_tick && frame_end;
            frame_start <= wrap_q;
            if (pix_tick) begin
                Posx    <= posx_nxt;
                Posy    <= posy_nxt;
                h_state <= h_nxt;
            end
        end else begin
            pix_tick    <= 1'b0;
            frame_start <= 1'b0;
        end
    end

    assign hsync    = (h_state != H_SYNC);
    assign vsync    = !((Posy >= Y_SYN0) && (Posy < Y_SYN1));
    assign video_on = (Posx < X_FRONT) && (Posy < Y_VIS);

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl: three instances (default DIV=2, DIV=1, tiny geometry
// DIV=3) checked every cycle against an arithmetic pixel-index model.
module tb_vga_sync_ctrl;

    logic Clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;

    always #5 Clk = ~Clk;

    logic       a_tick, a_hs, a_vs, a_vo, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_tick, b_hs, b_vs, b_vo, b_fs;
    logic [9:0] b_x, b_y;
    logic       c_tick, c_hs, c_vs, c_vo, c_fs;
    logic [9:0] c_x, c_y;

    vga_sync_ctrl #(.DIV(2)) u_a (
        .Clk(Clk), .reset(reset), .en(en), .pix_tick(a_tick), .Posx(a_x), .Posy(a_y),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_vo), .frame_start(a_fs)
    );

    vga_sync_ctrl #(.DIV(1)) u_b (
        .Clk(Clk), .reset(reset), .en(en), .pix_tick(b_tick), .Posx(b_x), .Posy(b_y),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_vo), .frame_start(b_fs)
    );

    vga_sync_ctrl #(
        .DIV(3), .H_VIS(8), .H_FP(2), .H_SYN(3), .H_BP(2),
        .V_VIS(5), .V_FP(1), .V_SYN(2), .V_BP(1)
    ) u_c (
        .Clk(Clk), .reset(reset), .en(en), .pix_tick(c_tick), .Posx(c_x), .Posy(c_y),
        .hsync(c_hs), .vsync(c_vs), .video_on(c_vo), .frame_start(c_fs)
    );

    logic [24:0] act [3];
    assign act[0] = {a_tick, a_fs, a_hs, a_vs, a_vo, a_x, a_y};
    assign act[1] = {b_tick, b_fs, b_hs, b_vs, b_vo, b_x, b_y};
    assign act[2] = {c_tick, c_fs, c_hs, c_vs, c_vo, c_x, c_y};

    // Per-instance timing in plain numbers; sync ranges are [lo, hi).
    int m_div  [3] = '{2, 1, 3};
    int m_ht   [3] = '{800, 800, 15};
    int m_vt   [3] = '{525, 525, 9};
    int m_hvis [3] = '{640, 640, 8};
    int m_hs0  [3] = '{656, 656, 10};
    int m_hs1  [3] = '{752, 752, 13};
    int m_vvis [3] = '{480, 480, 5};
    int m_vs0  [3] = '{490, 490, 6};
    int m_vs1  [3] = '{492, 492, 8};

    // Model state: divider phase, tick, linear pixel index within the frame.
    int md [3];
    bit mt [3];
    int mk [3];
    bit mp [3];
    bit mf [3];
    bit mvalid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] req);
        n_checks++;
        if (actual !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, actual, req, $time);
        end
    endtask

    task automatic model_update();
        bit wrapped;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                md[i] = 0; mt[i] = 0; mk[i] = 0; mp[i] = 0; mf[i] = 0;
            end else if (en) begin
                wrapped = 0;
                if (mt[i]) begin
                    mk[i]   = (mk[i] + 1) % (m_ht[i] * m_vt[i]);
                    wrapped = (mk[i] == 0);
                end
                mf[i] = mp[i];
                mp[i] = wrapped;
                mt[i] = (md[i] == m_div[i] - 1);
                md[i] = (md[i] + 1) % m_div[i];
            end else begin
                mt[i] = 0;
                mf[i] = 0;
            end
        end
        if (reset) mvalid = 1'b1;
    endtask

    function automatic logic [24:0] model_out(input int i);
        int x, y;
        logic hs, vs, vo;
        x  = mk[i] % m_ht[i];
        y  = mk[i] / m_ht[i];
        hs = !(x >= m_hs0[i] && x < m_hs1[i]);
        vs = !(y >= m_vs0[i] && y < m_vs1[i]);
        vo = (x < m_hvis[i]) && (y < m_vvis[i]);
        return {mt[i], mf[i], hs, vs, vo, x[9:0], y[9:0]};
    endfunction

    task automatic step();
        logic [24:0] exp_v;
        @(posedge Clk);
        model_update();
        #1;
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                exp_v = model_out(i);
                n_checks++;
                if (act[i] !== exp_v) begin
                    n_fail++;
                    $display("FAIL model_cmp inst%0d t=%0t got=%h required=%h",
                             i, $time, act[i], exp_v);
                end
            end
        end
    endtask

    typedef struct packed {
        logic rst;
        logic en;
        int   ax;
        logic at;
        int   bx;
        logic bt;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int   cnt, cnt2, mn, mx, y0, prev;
        bit   found;

        tbl[0]  = '{1'b1, 1'b1, 0, 1'b0, 0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 0, 1'b0, 0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 0, 1'b1, 1, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1, 1'b0, 2, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1, 1'b1, 3, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1, 1'b0, 3, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1, 1'b0, 3, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1, 1'b0, 3, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1, 1'b1, 4, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 2, 1'b0, 5, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 0, 1'b0, 0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 0, 1'b0, 0, 1'b0};

        reset = 1'b1; en = 1'b0;
        step(); step();

        for (int r = 0; r < 12; r++) begin
            reset = tbl[r].rst;
            en    = tbl[r].en;
            step();
            check($sformatf("tbl%0d_a_posx", r), 32'(a_x), tbl[r].ax);
            check($sformatf("tbl%0d_a_tick", r), 32'(a_tick), 32'(tbl[r].at));
            check($sformatf("tbl%0d_b_posx", r), 32'(b_x), tbl[r].bx);
            check($sformatf("tbl%0d_b_tick", r), 32'(b_tick), 32'(tbl[r].bt));
        end
        check("rst_hsync", 32'(a_hs), 1);
        check("rst_vsync", 32'(a_vs), 1);
        check("rst_video_on", 32'(a_vo), 1);
        check("rst_frame_start", 32'(a_fs), 0);
        check("rst_posy", 32'(a_y), 0);

        // en gap at Posx=300
        reset = 1'b0; en = 1'b1;
        found = 0;
        for (int n = 0; n < 3000 && !found; n++) begin
            step();
            if (a_x == 10'd300) found = 1;
        end
        check("reach_x300", 32'(found), 1);
        en = 1'b0;
        for (int n = 0; n < 37; n++) begin
            step();
            check("gap_hold_x", 32'(a_x), 300);
            check("gap_tick", 32'(a_tick), 0);
        end
        en = 1'b1;
        found = 0;
        for (int n = 0; n < 10 && !found; n++) begin
            step();
            if (a_x != 10'd300) found = 1;
        end
        check("resume_x", 32'(a_x), 301);

        // One full line on the DIV=2 instance
        found = 0;
        for (int n = 0; n < 2000 && !found; n++) begin
            step();
            if (a_x == 10'd0) found = 1;
        end
        check("reach_line_start", 32'(found), 1);
        y0 = int'(a_y);
        cnt = 0; cnt2 = 0; mn = 1023; mx = -1;
        for (int n = 0; n < 1600; n++) begin
            step();
            if (a_hs == 1'b0) begin
                cnt++;
                if (int'(a_x) < mn) mn = int'(a_x);
                if (int'(a_x) > mx) mx = int'(a_x);
            end
            if (a_vo != (a_x < 10'd640)) cnt2++;
        end
        check("a_hsync_low_clks", cnt, 192);
        check("a_hsync_first_x", mn, 656);
        check("a_hsync_last_x", mx, 751);
        check("a_video_on_bad", cnt2, 0);
        check("a_line_wrap_x", 32'(a_x), 0);
        check("a_line_wrap_y", 32'(a_y), (y0 + 1) % 525);

        // DIV=1 line length
        found = 0; prev = int'(b_x);
        for (int n = 0; n < 2000 && !found; n++) begin
            step();
            if (prev == 799 && b_x == 10'd0) found = 1;
            prev = int'(b_x);
        end
        check("b_reach_wrap", 32'(found), 1);
        found = 0; cnt = 0; cnt2 = 0;
        for (int n = 0; n < 2000 && !found; n++) begin
            step();
            cnt++;
            if (b_hs == 1'b0) cnt2++;
            if (prev == 799 && b_x == 10'd0) found = 1;
            prev = int'(b_x);
        end
        check("b_line_clks", cnt, 800);
        check("b_hsync_low_clks", cnt2, 96);

        // Full frame on the small-geometry instance
        found = 0;
        for (int n = 0; n < 1000 && !found; n++) begin
            step();
            if (c_fs) found = 1;
        end
        check("c_first_frame_start", 32'(found), 1);
        check("c_fs_posx", 32'(c_x), 0);
        check("c_fs_posy", 32'(c_y), 0);
        found = 0; cnt = 0; cnt2 = 0; mn = 1023; mx = -1;
        for (int n = 0; n < 1000 && !found; n++) begin
            step();
            cnt++;
            if (c_fs) found = 1;
            if (int'(c_y) > mx) mx = int'(c_y);
            if (c_vs == 1'b0) begin
                cnt2++;
                if (int'(c_y) < mn) mn = int'(c_y);
            end
        end
        check("c_frame_clks", cnt, 405);
        check("c_vsync_low_clks", cnt2, 90);
        check("c_vsync_first_y", mn, 6);
        check("c_max_posy", mx, 8);

        // Reset while both syncs are low
        found = 0;
        for (int n = 0; n < 1000 && !found; n++) begin
            step();
            if (c_hs == 1'b0 && c_vs == 1'b0) found = 1;
        end
        check("c_reach_sync", 32'(found), 1);
        reset = 1'b1;
        step();
        check("mid_rst_posx", 32'(c_x), 0);
        check("mid_rst_posy", 32'(c_y), 0);
        check("mid_rst_hsync", 32'(c_hs), 1);
        check("mid_rst_vsync", 32'(c_vs), 1);
        check("mid_rst_tick", 32'(c_tick), 0);
        check("mid_rst_fs", 32'(c_fs), 0);
        check("mid_rst_a_posx", 32'(a_x), 0);
        reset = 1'b0;

        // Random enable / occasional reset, model checked each cycle
        for (int n = 0; n < 3000; n++) begin
            en    = ($urandom_range(0, 9) != 0);
            reset = ($urandom_range(0, 999) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
